// File: rtl/tcdm_bank_arbiter_if.sv
// Master-side crossbar ports, single bank port and status of one TCDM bank arbiter.
// No logic inside; request path is combinational through the arbiter, responses come from its index FIFO.
// Backpressure: gnt/gnt_i on requests, rready/rready_o on read responses.
interface tcdm_bank_arbiter_if #(
  parameter int NUM_MASTERS     = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  // master side
  logic [NUM_MASTERS-1:0]                 req_i;
  logic [NUM_MASTERS-1:0]                 wen_i;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] addr_i;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NUM_MASTERS-1:0]                 gnt_o;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] rdata_o;
  logic [NUM_MASTERS-1:0]                 rvalid_o;
  logic [NUM_MASTERS-1:0]                 rready_i;

  // bank side
  logic                  req_o;
  logic                  wen_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic [IW-1:0]         master_idx_o;
  logic                  gnt_i;
  logic [DATA_WIDTH-1:0] rdata_i;
  logic                  rvalid_i;
  logic                  rready_o;

  // status
  logic [CW-1:0]         outstanding_o;
  logic                  err_o;

  // arbiter view
  modport slave (
    input  req_i, wen_i, addr_i, wdata_i, rready_i,
    input  gnt_i, rdata_i, rvalid_i,
    output gnt_o, rdata_o, rvalid_o,
    output req_o, wen_o, addr_o, wdata_o, master_idx_o, rready_o,
    output outstanding_o, err_o
  );

  // environment view (masters plus bank)
  modport master (
    output req_i, wen_i, addr_i, wdata_i, rready_i,
    output gnt_i, rdata_i, rvalid_i,
    input  gnt_o, rdata_o, rvalid_o,
    input  req_o, wen_o, addr_o, wdata_o, master_idx_o, rready_o,
    input  outstanding_o, err_o
  );
endinterface

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter sharing one TCDM bank among NUM_MASTERS; read responses steered back via an index FIFO.
// Latency: request/grant path combinational (0 cycles); responses combinational from the registered FIFO head.
// Backpressure: reads masked while the index FIFO is full; bank rvalid held off by the head master's rready.
module tcdm_bank_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic             clk_i,
  input logic             rst_i,
  tcdm_bank_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // arbitration state
  logic [IW-1:0] ptr_q;
  logic          lock_q;
  logic [IW-1:0] lock_idx_q;

  // read-index FIFO state
  logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          err_q;

  // combinational signals
  logic [NUM_MASTERS-1:0]                 elig;
  logic                                   found;
  logic [IW-1:0]                          win_idx;
  logic                                   hs;
  logic                                   push;
  logic                                   pop;
  logic                                   fifo_full;
  logic                                   fifo_empty;
  logic [IW-1:0]                          head;
  logic                                   win_wen;
  logic [ADDR_WIDTH-1:0]                  win_addr;
  logic [DATA_WIDTH-1:0]                  win_wdata;
  logic [NUM_MASTERS-1:0]                 gnt_vec;
  logic [NUM_MASTERS-1:0]                 rvalid_vec;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] rdata_vec;
  logic                                   rready_bank;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // full check deliberately uses only the registered count: a same-cycle pop never unmasks reads
  assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  // eligibility: writes always compete, reads only while the FIFO has room
  always_comb begin
    elig = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      elig[m] = bus.req_i[m] & (bus.wen_i[m] | ~fifo_full);
    end
  end

  // winner select: locked index wins outright, otherwise first eligible scanning from ptr
  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    found    = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    if (lock_q) begin
      found   = 1'b1;
      win_idx = lock_idx_q;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        cand = int'(ptr_q) + i;
        if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
        cand_idx = IW'(cand);
        if (!found && elig[cand_idx]) begin
          found   = 1'b1;
          win_idx = cand_idx;
        end
      end
    end
  end

  // bank request mux and master grant; grants are suppressed while reset is held
  always_comb begin
    win_wen   = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    gnt_vec   = '0;
    if (found) begin
      win_wen   = bus.wen_i[win_idx];
      win_addr  = bus.addr_i[win_idx];
      win_wdata = bus.wdata_i[win_idx];
    end
    if (hs) gnt_vec[win_idx] = 1'b1;
  end

  assign hs   = found & bus.gnt_i & ~rst_i;
  assign push = hs & ~win_wen;

  // response steering from the FIFO head; nothing is forwarded while the FIFO is empty
  always_comb begin
    rvalid_vec  = '0;
    rdata_vec   = '0;
    rready_bank = 1'b0;
    if (!fifo_empty) begin
      rvalid_vec[head] = bus.rvalid_i;
      rdata_vec[head]  = bus.rdata_i;
      rready_bank      = bus.rready_i[head];
    end
  end

  assign pop = bus.rvalid_i & rready_bank;

  // round-robin pointer and request lock
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      if (hs) begin
        ptr_q  <= (win_idx == IW'(NUM_MASTERS - 1)) ? '0 : win_idx + IW'(1);
        lock_q <= 1'b0;
      end else if (found && !bus.gnt_i) begin
        lock_q     <= 1'b1;
        lock_idx_q <= win_idx;
      end
    end
  end

  // FIFO pointers, occupancy and sticky spurious-response flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= inc_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= inc_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (bus.rvalid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  // FIFO storage needs no reset: entries are only read below the occupancy count
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= win_idx;
  end

  assign bus.req_o         = found;
  assign bus.wen_o         = win_wen;
  assign bus.addr_o        = win_addr;
  assign bus.wdata_o       = win_wdata;
  assign bus.master_idx_o  = win_idx;
  assign bus.gnt_o         = gnt_vec;
  assign bus.rvalid_o      = rvalid_vec;
  assign bus.rdata_o       = rdata_vec;
  assign bus.rready_o      = rready_bank;
  assign bus.outstanding_o = count_q;
  assign bus.err_o         = err_q;
endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Directed bench for tcdm_bank_arbiter: a cycle table for arbitration, FIFO and response routing,
// followed by hand sequences for lock, reset mid-operation and the spurious-response flag.
module tb_tcdm_bank_arbiter;
  localparam int NM = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MO = 4;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  tcdm_bank_arbiter_if #(.NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) bus ();

  tcdm_bank_arbiter #(.NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  wen;
    logic        gnt;
    logic        rv;
    logic [3:0]  rr;
    logic [31:0] rdata;
    logic        e_req;
    logic [3:0]  e_gnt;
    logic [1:0]  e_idx;
    logic        e_wen;
    logic [3:0]  e_rv;
    logic        e_rr;
    logic [2:0]  e_out;
    logic        e_err;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NM-1:0][DW-1:0] exp_rd;
    n_chk  = 0;
    n_fail = 0;

    //          req    wen    gnt   rv    rr     rdata          e_req e_gnt  idx    e_wen e_rv   e_rr  out    err
    tbl[0]  = '{4'hF, 4'h0, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 1'b1, 4'h1, 2'd0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0};
    tbl[1]  = '{4'hF, 4'h0, 1'b1, 1'b1, 4'hF, 32'h0000_0101, 1'b1, 4'h2, 2'd1, 1'b0, 4'h1, 1'b1, 3'd1, 1'b0};
    tbl[2]  = '{4'hF, 4'h0, 1'b1, 1'b1, 4'hF, 32'h0000_0102, 1'b1, 4'h4, 2'd2, 1'b0, 4'h2, 1'b1, 3'd1, 1'b0};
    tbl[3]  = '{4'hF, 4'h0, 1'b1, 1'b1, 4'hF, 32'h0000_0103, 1'b1, 4'h8, 2'd3, 1'b0, 4'h4, 1'b1, 3'd1, 1'b0};
    tbl[4]  = '{4'hF, 4'h0, 1'b1, 1'b1, 4'hF, 32'h0000_0104, 1'b1, 4'h1, 2'd0, 1'b0, 4'h8, 1'b1, 3'd1, 1'b0};
    tbl[5]  = '{4'h0, 4'h0, 1'b1, 1'b1, 4'hF, 32'h0000_0105, 1'b0, 4'h0, 2'd0, 1'b0, 4'h1, 1'b1, 3'd1, 1'b0};
    tbl[6]  = '{4'h0, 4'h0, 1'b1, 1'b0, 4'hF, 32'h0000_0106, 1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0};
    // fill the FIFO with reads from masters 0,2,3 starting at ptr 1
    tbl[7]  = '{4'hD, 4'h0, 1'b1, 1'b0, 4'hF, 32'h0000_0107, 1'b1, 4'h4, 2'd2, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0};
    tbl[8]  = '{4'hD, 4'h0, 1'b1, 1'b0, 4'hF, 32'h0000_0108, 1'b1, 4'h8, 2'd3, 1'b0, 4'h0, 1'b1, 3'd1, 1'b0};
    tbl[9]  = '{4'hD, 4'h0, 1'b1, 1'b0, 4'hF, 32'h0000_0109, 1'b1, 4'h1, 2'd0, 1'b0, 4'h0, 1'b1, 3'd2, 1'b0};
    tbl[10] = '{4'hD, 4'h0, 1'b1, 1'b0, 4'hF, 32'h0000_010A, 1'b1, 4'h4, 2'd2, 1'b0, 4'h0, 1'b1, 3'd3, 1'b0};
    // full: only the write from master 1 competes
    tbl[11] = '{4'hF, 4'h2, 1'b1, 1'b0, 4'hF, 32'h0000_010B, 1'b1, 4'h2, 2'd1, 1'b1, 4'h0, 1'b1, 3'd4, 1'b0};
    tbl[12] = '{4'hD, 4'h0, 1'b1, 1'b0, 4'hF, 32'h0000_010C, 1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b1, 3'd4, 1'b0};
    // pop in the same cycle does not unmask the read
    tbl[13] = '{4'h1, 4'h0, 1'b1, 1'b1, 4'hF, 32'h0000_010D, 1'b0, 4'h0, 2'd0, 1'b0, 4'h4, 1'b1, 3'd4, 1'b0};
    // head is master 3, held off for two cycles
    tbl[14] = '{4'h0, 4'h0, 1'b1, 1'b1, 4'h7, 32'hDEAD_BEEF, 1'b0, 4'h0, 2'd0, 1'b0, 4'h8, 1'b0, 3'd3, 1'b0};
    tbl[15] = '{4'h0, 4'h0, 1'b1, 1'b1, 4'h7, 32'hDEAD_BEEF, 1'b0, 4'h0, 2'd0, 1'b0, 4'h8, 1'b0, 3'd3, 1'b0};
    tbl[16] = '{4'h0, 4'h0, 1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 4'h0, 2'd0, 1'b0, 4'h8, 1'b1, 3'd3, 1'b0};
    // push and pop together at count 2
    tbl[17] = '{4'h2, 4'h0, 1'b1, 1'b1, 4'hF, 32'h0000_0111, 1'b1, 4'h2, 2'd1, 1'b0, 4'h1, 1'b1, 3'd2, 1'b0};
    tbl[18] = '{4'h0, 4'h0, 1'b1, 1'b1, 4'hF, 32'h0000_0112, 1'b0, 4'h0, 2'd0, 1'b0, 4'h4, 1'b1, 3'd2, 1'b0};
    tbl[19] = '{4'h0, 4'h0, 1'b1, 1'b1, 4'hF, 32'h0000_0113, 1'b0, 4'h0, 2'd0, 1'b0, 4'h2, 1'b1, 3'd1, 1'b0};
    tbl[20] = '{4'h0, 4'h0, 1'b1, 1'b0, 4'hF, 32'h0000_0114, 1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0};
    // spurious response with the FIFO empty
    tbl[21] = '{4'h0, 4'h0, 1'b1, 1'b1, 4'hF, 32'h0000_0115, 1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0};
    tbl[22] = '{4'h0, 4'h0, 1'b1, 1'b0, 4'hF, 32'h0000_0116, 1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b1};

    // static payloads: address 0x1000+m, write data 0xA0+m
    for (int m = 0; m < NM; m++) begin
      bus.addr_i[m]  = AW'(32'h1000 + m);
      bus.wdata_i[m] = DW'(32'hA0 + m);
    end
    bus.req_i    = '0;
    bus.wen_i    = '0;
    bus.rready_i = '0;
    bus.gnt_i    = 1'b0;
    bus.rdata_i  = '0;
    bus.rvalid_i = 1'b0;
    rst          = 1'b1;

    // reset state
    #2;
    chk("rst_req",    128'(bus.req_o), 128'(0));
    chk("rst_gnt",    128'(bus.gnt_o), 128'(0));
    chk("rst_rvalid", 128'(bus.rvalid_o), 128'(0));
    chk("rst_rready", 128'(bus.rready_o), 128'(0));
    chk("rst_out",    128'(bus.outstanding_o), 128'(0));
    chk("rst_err",    128'(bus.err_o), 128'(0));
    bus.req_i    = 4'h1;
    bus.gnt_i    = 1'b1;
    bus.rvalid_i = 1'b1;
    #1;
    chk("rst_req_present", 128'(bus.req_o), 128'(1));
    chk("rst_gnt_masked",  128'(bus.gnt_o), 128'(0));
    chk("rst_rvalid_mask", 128'(bus.rvalid_o), 128'(0));
    step();
    step();
    rst = 1'b0;

    // table-driven cycles
    for (int i = 0; i < NV; i++) begin
      bus.req_i    = tbl[i].req;
      bus.wen_i    = tbl[i].wen;
      bus.gnt_i    = tbl[i].gnt;
      bus.rvalid_i = tbl[i].rv;
      bus.rready_i = tbl[i].rr;
      bus.rdata_i  = tbl[i].rdata;
      #3;
      chk($sformatf("v%0d_req", i),    128'(bus.req_o), 128'(tbl[i].e_req));
      chk($sformatf("v%0d_gnt", i),    128'(bus.gnt_o), 128'(tbl[i].e_gnt));
      chk($sformatf("v%0d_idx", i),    128'(bus.master_idx_o), 128'(tbl[i].e_idx));
      chk($sformatf("v%0d_wen", i),    128'(bus.wen_o), 128'(tbl[i].e_wen));
      chk($sformatf("v%0d_addr", i),   128'(bus.addr_o),
          tbl[i].e_req ? 128'(32'h1000 + 32'(tbl[i].e_idx)) : 128'(0));
      chk($sformatf("v%0d_wdata", i),  128'(bus.wdata_o),
          tbl[i].e_req ? 128'(32'hA0 + 32'(tbl[i].e_idx)) : 128'(0));
      chk($sformatf("v%0d_rvalid", i), 128'(bus.rvalid_o), 128'(tbl[i].e_rv));
      chk($sformatf("v%0d_rready", i), 128'(bus.rready_o), 128'(tbl[i].e_rr));
      chk($sformatf("v%0d_out", i),    128'(bus.outstanding_o), 128'(tbl[i].e_out));
      chk($sformatf("v%0d_err", i),    128'(bus.err_o), 128'(tbl[i].e_err));
      if (tbl[i].e_rv != 4'h0) begin
        exp_rd = '0;
        for (int m = 0; m < NM; m++) begin
          if (tbl[i].e_rv[m]) exp_rd[m] = tbl[i].rdata;
        end
        chk($sformatf("v%0d_rdata", i), 128'(bus.rdata_o), 128'(exp_rd));
      end
      step();
    end

    // sticky error persists, then clears on reset
    bus.rvalid_i = 1'b0;
    #3;
    chk("err_sticky", 128'(bus.err_o), 128'(1));
    rst = 1'b1;
    #1;
    chk("err_cleared", 128'(bus.err_o), 128'(0));
    step();
    rst = 1'b0;
    step();

    // lock: master 2 stalls, master 0 arrives but must wait
    bus.req_i    = 4'h4;
    bus.wen_i    = 4'h0;
    bus.gnt_i    = 1'b0;
    bus.rready_i = 4'h0;
    #3;
    chk("lock_c0_idx", 128'(bus.master_idx_o), 128'(2));
    chk("lock_c0_gnt", 128'(bus.gnt_o), 128'(0));
    step();
    bus.req_i = 4'h5;
    for (int c = 1; c < 3; c++) begin
      #3;
      chk($sformatf("lock_c%0d_idx", c),  128'(bus.master_idx_o), 128'(2));
      chk($sformatf("lock_c%0d_addr", c), 128'(bus.addr_o), 128'(32'h1002));
      chk($sformatf("lock_c%0d_req", c),  128'(bus.req_o), 128'(1));
      step();
    end
    bus.gnt_i = 1'b1;
    #3;
    chk("lock_rel_gnt", 128'(bus.gnt_o), 128'(4'h4));
    step();
    bus.req_i = 4'h1;
    #3;
    chk("lock_next_idx", 128'(bus.master_idx_o), 128'(0));
    chk("lock_next_gnt", 128'(bus.gnt_o), 128'(4'h1));
    step();
    bus.req_i = 4'h0;
    bus.gnt_i = 1'b0;
    #3;
    chk("pre_reset_out", 128'(bus.outstanding_o), 128'(2));

    // reset mid-operation discards the queue immediately
    rst = 1'b1;
    #1;
    chk("midrst_out", 128'(bus.outstanding_o), 128'(0));
    step();
    rst          = 1'b0;
    bus.rvalid_i = 1'b1;
    bus.rready_i = 4'hF;
    #3;
    chk("late_rsp_rvalid", 128'(bus.rvalid_o), 128'(0));
    chk("late_rsp_rready", 128'(bus.rready_o), 128'(0));
    chk("late_rsp_err0",   128'(bus.err_o), 128'(0));
    step();
    bus.rvalid_i = 1'b0;
    #3;
    chk("late_rsp_err1", 128'(bus.err_o), 128'(1));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
